// File: rtl/gru_sequence_controller.sv
// Steps a GRU cell over a frame sequence, recirculating the hidden state between steps.
// Latency: 4 cycles per step plus cell time; x_valid/y_ready stalls hold the FSM in FETCH/EMIT.
module gru_sequence_controller #(
  parameter int D          = 64,
  parameter int H          = 16,
  parameter int DATA_WIDTH = 21,
  parameter int MAX_T      = 256,
  parameter int TW         = $clog2(MAX_T + 1),
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seq_start,
  input  logic [TW-1:0]              seq_len,
  input  logic                       h0_zero,
  input  logic [H*DATA_WIDTH-1:0]    h_init,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [D*DATA_WIDTH-1:0]    x_data,
  output logic                       cell_start,
  input  logic                       cell_done,
  output logic [D*DATA_WIDTH-1:0]    cell_x,
  output logic [H*DATA_WIDTH-1:0]    cell_h_prev,
  input  logic [H*DATA_WIDTH-1:0]    cell_h,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [H*DATA_WIDTH-1:0]    y_data,
  output logic                       y_last,
  output logic [TW-1:0]              step_idx,
  output logic                       busy,
  output logic                       seq_done,
  output logic                       err_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, EMIT, FINISH} state_t;

  state_t                    state;
  logic [TW-1:0]             last_idx;
  logic [TW-1:0]             len_c;
  logic [CW-1:0]             tmo_cnt;
  logic [H*DATA_WIDTH-1:0]   h_reg;
  logic [H*DATA_WIDTH-1:0]   y_reg;
  logic [D*DATA_WIDTH-1:0]   x_reg;

  assign len_c = (seq_len > TW'(MAX_T)) ? TW'(MAX_T) : seq_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_idx    <= '0;
      tmo_cnt     <= '0;
      h_reg       <= '0;
      y_reg       <= '0;
      x_reg       <= '0;
      step_idx    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seq_start) begin
            // last_idx wraps for a zero length, but that path goes straight to FINISH
            last_idx    <= len_c - TW'(1);
            h_reg       <= h0_zero ? '0 : h_init;
            step_idx    <= '0;
            err_timeout <= 1'b0;
            state       <= (len_c == '0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          if (x_valid) begin
            x_reg <= x_data;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (cell_done) begin
            h_reg <= cell_h;
            y_reg <= cell_h;
            state <= EMIT;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            // abandon the step: hidden state keeps its pre-launch value
            err_timeout <= 1'b1;
            state       <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        EMIT: begin
          if (y_ready) begin
            if (step_idx == last_idx) begin
              state <= FINISH;
            end else begin
              step_idx <= step_idx + TW'(1);
              state    <= FETCH;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign x_ready     = (state == FETCH);
  assign cell_start  = (state == LAUNCH);
  assign y_valid     = (state == EMIT);
  assign y_last      = (state == EMIT) && (step_idx == last_idx);
  assign busy        = (state != IDLE);
  assign seq_done    = (state == FINISH);
  assign y_data      = y_reg;
  assign cell_x      = x_reg;
  assign cell_h_prev = h_reg;

endmodule

// File: doc/gru_sequence_controller.md
# gru_sequence_controller

Sequences the GRU cell over a multi-timestep input sequence. It accepts input frames over a valid/ready handshake and launches one `cell_start`/`cell_done` transaction per timestep. It feeds each step's hidden-state result back as the next `h_t_prev` and streams every per-step hidden state out under backpressure. It sits between the frame source and the GRU cell datapath and owns the recurrent hidden-state register.

## Interface
- `D`, 64, input feature count per frame
- `H`, 16, hidden units
- `DATA_WIDTH`, 21, signed fixed-point word width (10 integer + 11 fractional bits)
- `MAX_T`, 256, maximum sequence length
- `TW`, $clog2(MAX_T+1), width of length/step counters
- `TIMEOUT`, 1024, maximum cycles to wait for `cell_done`

Ports:
- `clk` in 1: single clock, all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `seq_start` in 1: pulse to begin a sequence; sampled only in IDLE
- `seq_len` in TW: timestep count, latched on an accepted `seq_start`; values above `MAX_T` are clamped to `MAX_T`
- `h0_zero` in 1: latched on an accepted `seq_start`; 1 = initial hidden state all zeros, 0 = use `h_init`
- `h_init` in H*DATA_WIDTH: initial hidden state, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `x_valid` in 1 / `x_ready` out 1 / `x_data` in D*DATA_WIDTH: input frame handshake
- `cell_start` out 1: one-cycle launch pulse to the GRU cell
- `cell_done` in 1: GRU cell completion
- `cell_x` out D*DATA_WIDTH: registered frame driven to the cell
- `cell_h_prev` out H*DATA_WIDTH: registered hidden state driven to the cell
- `cell_h` in H*DATA_WIDTH: cell result, valid while `cell_done`=1
- `y_valid` out 1 / `y_ready` in 1 / `y_data` out H*DATA_WIDTH / `y_last` out 1: per-step output stream
- `step_idx` out TW: index of the current timestep
- `busy` out 1: high in every state except IDLE
- `seq_done` out 1: one-cycle pulse at sequence end
- `err_timeout` out 1: sticky flag; cleared on an accepted `seq_start` or on `rst`

## Operation
FSM states: IDLE, FETCH, LAUNCH, WAIT, EMIT, FINISH.

- **IDLE**
  - On `seq_start`: latch the clamped length, load `h_reg` (zeros or `h_init`), clear `step_idx` and `err_timeout`.
  - Next state is FINISH if the length is 0, otherwise FETCH.
- **FETCH**
  - `x_ready`=1.
  - On `x_valid`: `x_reg`←`x_data`, next state LAUNCH.
- **LAUNCH**
  - `cell_start`=1 for exactly this cycle.
  - Clear the timeout counter; next state WAIT.
- **WAIT**
  - Timeout counter increments every cycle.
  - On `cell_done`: `h_reg`←`cell_h`, `y_reg`←`cell_h`, next state EMIT.
  - If the counter reaches `TIMEOUT-1` without `cell_done`: set `err_timeout`, next state FINISH. `h_reg` is not updated and no output is emitted for that step.
- **EMIT**
  - `y_valid`=1; `y_data`=`y_reg`, held stable until accepted.
  - `y_last`=1 when `step_idx`==len−1.
  - On `y_ready`: if last step go to FINISH, else `step_idx`+1 and go to FETCH.
- **FINISH**
  - `seq_done`=1 for one cycle; next state IDLE.

Rules:
- `cell_x`=`x_reg` and `cell_h_prev`=`h_reg` at all times; both are stable from LAUNCH until `cell_done`.
- Any `cell_done` outside WAIT is ignored.
- `seq_start` outside IDLE is ignored.
- Data passes through unchanged; no arithmetic is performed on data words.
- `step_idx` never exceeds len−1.

## Timing
- Reset values: IDLE state. All outputs 0 (`x_ready`, `cell_start`, `y_valid`, `y_last`, `busy`, `seq_done`, `err_timeout`, `step_idx`). `h_reg`, `x_reg` and `y_reg` are cleared to 0.
- Reset asserted mid-sequence takes effect on the next edge: the controller returns to IDLE, `cell_start` is not reissued, and in-flight cell results are discarded.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- Step latency:
  - `seq_start` at cycle 0 puts the FSM in FETCH at cycle 1.
  - `x_valid` accepted at cycle k gives `cell_start` at k+1.
  - `cell_done` at cycle m gives `y_valid` at m+1.
  - `y_ready` at cycle n gives `x_ready` at n+1, or `seq_done` at n+1.
- Fixed overhead is 4 cycles per step plus the cell latency.
- `busy` falls 1 cycle after `seq_done`.
- With zero length, `seq_done` asserts at cycle 1 and no `cell_start` is issued.

## Test plan
- **Basic sequence:** `seq_len`=3, `h0_zero`=1, cell model returns `cell_h`=`h_prev`+1 after 5 cycles, `x_valid` and `y_ready` held high.
  - Outputs: `y_data` elements 1, 2, 3 over three beats, with `y_last` only on the third.
  - `seq_done` 1 cycle after the third accept; `cell_start` pulsed exactly 3 times.
- **Zero length:** `seq_len`=0.
  - `seq_done` at cycle 1, `busy` high for exactly one cycle, no `cell_start`, no `x_ready`.
- **Backpressure:** `y_ready` held low for 10 cycles, `x_valid` gapped.
  - `y_data` stable throughout the stall; no `x_ready` during EMIT; `cell_h_prev` equals the prior `y_data` at the next `cell_start`.
- **Timeout:** cell never asserts `cell_done`, `TIMEOUT`=16.
  - `err_timeout` rises after 16 WAIT cycles, then `seq_done` pulses and the FSM returns to IDLE.
  - The next `seq_start` clears `err_timeout`.
- **Initial state and clamping:** `h0_zero`=0, `h_init` element 0 = 0x00800 (1.0), `seq_len`=300 with `MAX_T`=256.
  - First `cell_h_prev` equals `h_init`; exactly 256 outputs are emitted.
- **Reset and spurious inputs:** `rst` asserted in WAIT, then a spurious `cell_done` and a `seq_start` while busy are also applied.
  - After the next edge all outputs are 0 and the state is IDLE.
  - The spurious `cell_done` and the busy-time `seq_start` are ignored.
